// File: rtl/wavetable_voice_mixer.sv
// Wavetable voice mixer: one ROM read per voice per tick, saturated sum, fixed-point phase advance.
// Tick-to-valid latency NUM_VOICES+2 cycles; no backpressure, ticks while busy are dropped and raise sticky overrun.
module wavetable_voice_mixer #(
    parameter int NUM_VOICES = 4,
    parameter int ADDR_W     = 7,
    parameter int DATA_W     = 32,
    parameter int FRAC_W     = 8
) (
    input  logic                                   clk_i,
    input  logic                                   rst_n_i,
    input  logic                                   sample_tick_i,
    input  logic [NUM_VOICES-1:0]                  key_on_i,
    input  logic [NUM_VOICES*(ADDR_W+FRAC_W)-1:0]  voice_inc_i,
    input  logic [ADDR_W-1:0]                      rom_len_i,
    output logic [ADDR_W-1:0]                      rom_read_address_o,
    input  logic [DATA_W-1:0]                      rom_data_i,
    output logic [DATA_W-1:0]                      sample_out_o,
    output logic                                   sample_valid_o,
    output logic                                   overrun_o
);
    localparam int PH_W  = ADDR_W + FRAC_W;
    localparam int ACC_W = DATA_W + 3;
    localparam int VW    = $clog2(NUM_VOICES + 1);

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                   state_q;
    logic [VW-1:0]            v_q;
    logic [NUM_VOICES-1:0]    mask_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic [PH_W-1:0]          phase_q [NUM_VOICES];
    logic [ADDR_W-1:0]        addr_q;
    logic [DATA_W-1:0]        sample_q;
    logic                     valid_q;
    logic                     ovr_q;

    logic signed [ACC_W-1:0]  rom_ext;
    logic signed [ACC_W-1:0]  acc_d;
    logic [DATA_W-1:0]        sat_d;
    logic [ADDR_W-1:0]        next_addr;
    logic [PH_W-1:0]          phase_d [NUM_VOICES];
    logic                     take;
    logic [VW-1:0]            dv;
    logic [PH_W:0]            p_sum;
    logic [PH_W:0]            p_wrap;
    logic [PH_W:0]            lim;

    assign rom_ext = {{(ACC_W-DATA_W){rom_data_i[DATA_W-1]}}, rom_data_i};

    // Data returning this cycle belongs to the voice addressed one cycle earlier.
    always_comb begin
        take = 1'b0;
        dv   = '0;
        if (state_q == S_ISSUE && v_q != '0) begin
            dv = v_q - VW'(1);
        end else if (state_q == S_DRAIN) begin
            dv = VW'(NUM_VOICES - 1);
        end
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (dv == VW'(i) && (state_q == S_DRAIN || (state_q == S_ISSUE && v_q != '0))) begin
                take = mask_q[i];
            end
        end
        acc_d = acc_q + (take ? rom_ext : '0);
    end

    always_comb begin
        if (acc_d > SAT_MAX) begin
            sat_d = SAT_MAX[DATA_W-1:0];
        end else if (acc_d < SAT_MIN) begin
            sat_d = SAT_MIN[DATA_W-1:0];
        end else begin
            sat_d = acc_d[DATA_W-1:0];
        end
    end

    always_comb begin
        next_addr = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (v_q + VW'(1) == VW'(i)) begin
                next_addr = phase_q[i][PH_W-1 -: ADDR_W];
            end
        end
    end

    // A double wrap can only happen when rom_len shrank or the increment exceeds the table.
    always_comb begin
        p_sum  = '0;
        p_wrap = '0;
        lim    = {1'b0, rom_len_i, {FRAC_W{1'b0}}};
        for (int i = 0; i < NUM_VOICES; i++) begin
            phase_d[i] = '0;
            p_sum  = {1'b0, phase_q[i]} + {1'b0, voice_inc_i[i*PH_W +: PH_W]};
            p_wrap = p_sum - lim;
            if (mask_q[i] && rom_len_i != '0) begin
                if (p_sum < lim) begin
                    phase_d[i] = p_sum[PH_W-1:0];
                end else if (p_wrap < lim) begin
                    phase_d[i] = p_wrap[PH_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= S_IDLE;
            v_q      <= '0;
            mask_q   <= '0;
            acc_q    <= '0;
            addr_q   <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                phase_q[i] <= '0;
            end
        end else begin
            valid_q <= 1'b0;
            if (sample_tick_i && state_q != S_IDLE) begin
                ovr_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (sample_tick_i) begin
                        mask_q  <= key_on_i;
                        acc_q   <= '0;
                        v_q     <= '0;
                        addr_q  <= phase_q[0][PH_W-1 -: ADDR_W];
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    acc_q <= acc_d;
                    if (v_q == VW'(NUM_VOICES - 1)) begin
                        state_q <= S_DRAIN;
                    end else begin
                        v_q    <= v_q + VW'(1);
                        addr_q <= next_addr;
                    end
                end
                S_DRAIN: begin
                    acc_q    <= acc_d;
                    sample_q <= sat_d;
                    valid_q  <= 1'b1;
                    for (int i = 0; i < NUM_VOICES; i++) begin
                        phase_q[i] <= phase_d[i];
                    end
                    state_q  <= S_DONE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rom_read_address_o = addr_q;
    assign sample_out_o       = sample_q;
    assign sample_valid_o     = valid_q;
    assign overrun_o          = ovr_q;

endmodule

// File: tb/tb_wavetable_voice_mixer.sv
// Bench for wavetable_voice_mixer: directed and random ticks checked against a table-level reference model.
module tb_wavetable_voice_mixer;
    localparam int NV = 4;
    localparam int AW = 7;
    localparam int DW = 32;
    localparam int FW = 8;
    localparam int PW = AW + FW;

    logic              clk;
    logic              rst_n = 1'b1;
    logic              tick = 1'b0;
    logic [NV-1:0]     key_on = '0;
    logic [NV*PW-1:0]  voice_inc = '0;
    logic [AW-1:0]     rom_len = '0;
    logic [AW-1:0]     rom_addr;
    logic [DW-1:0]     rom_data = '0;
    logic [DW-1:0]     sample_out;
    logic              sample_valid;
    logic              overrun;

    logic [DW-1:0]     rom_mem [128];
    int                m_phase [NV];
    int                m_inc   [NV];
    logic [DW-1:0]     last_sample = '0;
    logic              exp_ovr = 1'b0;
    int                checks = 0;
    int                errors = 0;

    wavetable_voice_mixer #(.NUM_VOICES(NV), .ADDR_W(AW), .DATA_W(DW), .FRAC_W(FW)) dut (
        .clk_i              (clk),
        .rst_n_i            (rst_n),
        .sample_tick_i      (tick),
        .key_on_i           (key_on),
        .voice_inc_i        (voice_inc),
        .rom_len_i          (rom_len),
        .rom_read_address_o (rom_addr),
        .rom_data_i         (rom_data),
        .sample_out_o       (sample_out),
        .sample_valid_o     (sample_valid),
        .overrun_o          (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_ramp();
        for (int a = 0; a < 128; a++) rom_mem[a] = a * 32'h0010_0000;
    endtask

    task automatic fill_const(input logic [DW-1:0] val);
        for (int a = 0; a < 128; a++) rom_mem[a] = val;
    endtask

    task automatic fill_rand();
        for (int a = 0; a < 128; a++) rom_mem[a] = $urandom;
    endtask

    task automatic set_inc(input int v, input int inc);
        m_inc[v] = inc;
        voice_inc[v*PW +: PW] = inc[PW-1:0];
    endtask

    // One tick at the current point; runs to the first cycle a new tick would be accepted.
    // ovr_at / rst_at: cycle offset after the tick of an extra tick / reset assertion (0 = none).
    task automatic do_seq(input int ovr_at, input int rst_at);
        int            exp_addr [NV];
        logic [NV-1:0] mask;
        longint        sum;
        logic [DW-1:0] exp_s;
        logic [NV-1:0] saved_key;
        bit            in_rst;
        int            p;
        int            lim;
        mask = key_on;
        saved_key = key_on;
        sum = 0;
        for (int v = 0; v < NV; v++) begin
            exp_addr[v] = m_phase[v] / 256;
            if (mask[v]) sum += longint'(int'(rom_mem[exp_addr[v]]));
        end
        if (sum > 64'sd2147483647) exp_s = 32'h7FFF_FFFF;
        else if (sum < -64'sd2147483648) exp_s = 32'h8000_0000;
        else exp_s = sum[31:0];

        tick = 1'b1;
        for (int c = 1; c <= NV + 3; c++) begin
            @(negedge clk);
            tick = (c == ovr_at);
            if (c == 2) key_on = NV'($urandom);
            if (c == NV + 3) key_on = saved_key;
            if (rst_at > 0 && c == rst_at) rst_n = 1'b0;
            #1;
            in_rst = (rst_at > 0 && c >= rst_at);
            if (in_rst) begin
                chk("rst_valid", sample_valid, 0);
                chk("rst_addr", rom_addr, 0);
                chk("rst_sample", sample_out, 0);
                chk("rst_ovr", overrun, 0);
            end else begin
                if (c <= NV) chk($sformatf("addr_v%0d", c - 1), rom_addr, exp_addr[c-1]);
                chk($sformatf("valid_c%0d", c), sample_valid, (c == NV + 2));
                chk("sample", sample_out, (c >= NV + 2) ? exp_s : last_sample);
                chk("ovr", overrun, (ovr_at > 0 && c > ovr_at) ? 1'b1 : exp_ovr);
            end
        end
        tick = 1'b0;

        if (rst_at > 0) begin
            rst_n = 1'b1;
            for (int v = 0; v < NV; v++) m_phase[v] = 0;
            last_sample = '0;
            exp_ovr = 1'b0;
        end else begin
            last_sample = exp_s;
            if (ovr_at > 0) exp_ovr = 1'b1;
            lim = int'(rom_len) * 256;
            for (int v = 0; v < NV; v++) begin
                if (!mask[v]) begin
                    m_phase[v] = 0;
                end else begin
                    p = m_phase[v] + m_inc[v];
                    if (p >= lim) p -= lim;
                    if (p >= lim) p = 0;
                    m_phase[v] = p;
                end
            end
        end
    endtask

    initial begin
        for (int v = 0; v < NV; v++) begin
            m_phase[v] = 0;
            m_inc[v] = 0;
        end
        fill_ramp();
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #1;
            chk("reset_sample", sample_out, 0);
            chk("reset_valid", sample_valid, 0);
            chk("reset_ovr", overrun, 0);
            chk("reset_addr", rom_addr, 0);
        end

        rom_len = 36;
        key_on = 4'b0001;
        set_inc(0, 32'h100);
        for (int k = 0; k < 3; k++) begin
            do_seq(0, 0);
            chk("step_const", sample_out, k * 32'h0010_0000);
        end

        key_on = 4'b0000;
        do_seq(0, 0);
        key_on = 4'b0001;
        set_inc(0, 32'h180);
        for (int k = 0; k < 26; k++) do_seq(0, 0);

        key_on = 4'b0000;
        do_seq(0, 0);
        key_on = 4'b0001;
        set_inc(0, 32'h2500);
        for (int k = 0; k < 38; k++) do_seq(0, 0);

        fill_const(32'h6000_0000);
        key_on = 4'b1111;
        for (int v = 0; v < NV; v++) set_inc(v, 32'h100 + v * 32'h40);
        do_seq(0, 0);
        chk("sat_pos", sample_out, 32'h7FFF_FFFF);
        fill_const(32'hA000_0000);
        do_seq(0, 0);
        chk("sat_neg", sample_out, 32'h8000_0000);

        fill_const(32'h0000_0010);
        key_on = 4'b1010;
        do_seq(0, 0);
        chk("mask_sum", sample_out, 32'h20);
        fill_ramp();
        do_seq(0, 0);
        key_on = 4'b0000;
        do_seq(0, 0);
        key_on = 4'b1111;
        do_seq(0, 0);

        do_seq(3, 0);
        do_seq(0, 0);

        do_seq(0, 4);
        do_seq(0, 0);

        for (int k = 0; k < 60; k++) begin
            if (k % 10 == 0) fill_rand();
            rom_len = (k % 13 == 5) ? AW'(0) : AW'($urandom_range(1, 127));
            key_on = NV'($urandom);
            for (int v = 0; v < NV; v++) set_inc(v, int'($urandom_range(0, 32'h7FFF)));
            do_seq((k % 17 == 8) ? int'($urandom_range(1, NV + 2)) : 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
